// File: rtl/gpp16_pkg.sv
// gpp16_pkg: definitions shared by the GPP16 instruction sequencer.
//   state_t        - sequencer FSM state encoding (also visible on the debug port)
//   OPC_MSB/OPC_LSB - position of the 5-bit opcode field inside an instruction
//   HALT/NOP codes  - default opcode values for the sequencer parameters
//   opcode_of()     - extracts the opcode field from an instruction word
//   sat_inc16()     - 16-bit increment that sticks at all-ones
package gpp16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] HALT_OPC_DEFAULT = 5'b11111;
    localparam logic [OPC_W-1:0] NOP_OPC_DEFAULT  = 5'b00000;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/gpp16_fetch_timer.sv
// gpp16_fetch_timer: counts consecutive FETCH cycles that see no imem_ack.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-low reset
//   clear   in  forces the count to zero (held while not fetching)
//   en      in  current cycle is a FETCH cycle without ack
//   expired out current cycle is the TIMEOUT-th consecutive unanswered cycle
module gpp16_fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // count holds the number of earlier unanswered cycles, so the cycle that
    // brings the total to TIMEOUT is the one where count == TIMEOUT-1.
    assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/gpp16_sequencer.sv
// gpp16_sequencer: fetch / decode / execute / write-back sequencer for a
// 16-bit processor with a 5-bit opcode in ir[15:11].
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   start               leaves IDLE and begins fetching at pc
//   imem_req/imem_addr  fetch request, address equals pc, held until ack
//   imem_ack/imem_data  fetch response, only honoured in FETCH
//   pc, ir              program counter and instruction register
//   alu_func, rf_we     opcode during EXEC/WB, register write strobe in WB
//   busy/halted/err     status flags, instr_cnt saturating retire count
//   fsm_state           current FSM state, for observation only
// Handshake: imem_req is asserted for every FETCH cycle with a stable
// imem_addr; a transfer completes on any rising edge where imem_req and
// imem_ack are both high (ack in the first request cycle is allowed). The
// request is never withdrawn except by reset.
module gpp16_sequencer
    import gpp16_pkg::*;
#(
    parameter logic [4:0] HALT_OPC      = HALT_OPC_DEFAULT,
    parameter logic [4:0] NOP_OPC       = NOP_OPC_DEFAULT,
    parameter int         FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [4:0]  alu_func,
    output logic        rf_we,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [15:0] instr_cnt,
    output state_t      fsm_state
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] cnt_q;
    logic [4:0]  opc;
    logic        timer_clear;
    logic        timer_en;
    logic        timer_expired;

    assign opc = opcode_of(ir_q);

    // Held clear outside FETCH, so every entry into FETCH starts from zero.
    assign timer_clear = (state != ST_FETCH);
    assign timer_en    = (state == ST_FETCH) && !imem_ack;

    gpp16_fetch_timer #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)           state_nxt = ST_DECODE;
                else if (timer_expired) state_nxt = ST_ERR;
            end
            ST_DECODE: begin
                if (opc == HALT_OPC)     state_nxt = ST_HALT;
                else if (opc == NOP_OPC) state_nxt = ST_FETCH;
                else                     state_nxt = ST_EXEC;
            end
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            ST_ERR:    state_nxt = ST_ERR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe, and imem_data never reaches an output directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pc_q     <= 16'd0;
            ir_q     <= 16'd0;
            cnt_q    <= 16'd0;
            imem_req <= 1'b0;
            rf_we    <= 1'b0;
            alu_func <= 5'd0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_FETCH && imem_ack) begin
                ir_q <= imem_data;
                pc_q <= pc_q + 16'd1;
            end

            // NOP retires straight out of DECODE, ALU ops retire in WB.
            if ((state == ST_DECODE && state_nxt == ST_FETCH) || state == ST_WB) begin
                cnt_q <= sat_inc16(cnt_q);
            end

            imem_req <= (state_nxt == ST_FETCH);
            rf_we    <= (state_nxt == ST_WB);
            alu_func <= (state_nxt == ST_EXEC || state_nxt == ST_WB) ? opc : 5'd0;
            busy     <= !(state_nxt == ST_IDLE || state_nxt == ST_HALT || state_nxt == ST_ERR);
            halted   <= (state_nxt == ST_HALT);
            err      <= (state_nxt == ST_ERR);
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign instr_cnt = cnt_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_gpp16_sequencer.sv
// Bench for gpp16_sequencer: table of short programs run to completion plus
// hand-written cycle-level sequences; a memory responder pushes the opcode of
// every ALU instruction it returns, and the rf_we monitor pops and compares.
module tb_gpp16_sequencer;
    import gpp16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [4:0]  alu_func;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] instr_cnt;
    state_t      fsm_state;

    always #5 clk = ~clk;

    gpp16_sequencer #(
        .HALT_OPC      (5'b11111),
        .NOP_OPC       (5'b00000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .pc        (pc),
        .ir        (ir),
        .alu_func  (alu_func),
        .rf_we     (rf_we),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt),
        .fsm_state (fsm_state)
    );

    int checks   = 0;
    int failures = 0;

    logic [4:0]  exp_q[$];
    logic [4:0]  mon_exp;
    logic [15:0] mem [0:255];
    logic        resp_on;
    logic        manual;
    int          resp_delay;
    int          wait_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: answers a request after resp_delay waiting cycles.
    always @(negedge clk) begin
        if (!manual) begin
            if (imem_req && resp_on) begin
                if (wait_cnt >= resp_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr[7:0]];
                    wait_cnt  = 0;
                    if (imem_data[15:11] != 5'b00000 && imem_data[15:11] != 5'b11111)
                        exp_q.push_back(imem_data[15:11]);
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard side: every write strobe must match the next expected opcode.
    always @(negedge clk) begin
        if (rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rf_we_unexpected alu_func=%0d expected no write", alu_func);
            end else begin
                mon_exp = exp_q.pop_front();
                if (alu_func !== mon_exp) begin
                    failures++;
                    $display("FAIL rf_we_alu_func actual=%0d expected=%0d", alu_func, mon_exp);
                end
            end
        end
    end

    task automatic do_reset();
        rst    = 1'b0;
        start  = 1'b0;
        manual = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic load_prog(input logic [3:0][15:0] prog);
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int j = 0; j < 4; j++) mem[j] = prog[j];
    endtask

    task automatic run_until_done(input int budget, output int cycles, output int pulses);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        pulses = 0;
        while (!(halted || err) && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (rf_we) pulses++;
        end
    endtask

    typedef struct {
        logic [3:0][15:0] prog;     // word3 .. word0
        int               delay;    // -1: memory never answers
        logic             exp_halted;
        logic             exp_err;
        logic [15:0]      exp_cnt;
        logic [15:0]      exp_pc;
        int               exp_cycles;
        int               exp_pulses;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    initial begin
        int cyc;
        int pulses;
        int req_cycles;
        int first_err;
        logic [15:0] pc_m;
        logic [15:0] cnt_m;

        rst = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
        resp_on = 1'b1; resp_delay = 0; manual = 1'b0; wait_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // cycles counted from the start edge; ALU=4+d, NOP=2+d, HALT=2+d
        vecs[0] = '{{16'h0000, 16'h0000, 16'hF800, 16'h0820}, 0, 1'b1, 1'b0, 16'd1, 16'd2, 7, 1};
        vecs[1] = '{{16'h0000, 16'hF800, 16'h0000, 16'h0000}, 0, 1'b1, 1'b0, 16'd2, 16'd3, 7, 0};
        vecs[2] = '{{16'hF800, 16'h7800, 16'h0000, 16'h1000}, 1, 1'b1, 1'b0, 16'd3, 16'd4, 17, 2};
        vecs[3] = '{{16'h0000, 16'h0000, 16'h0000, 16'hF800}, 2, 1'b1, 1'b0, 16'd0, 16'd1, 5, 0};
        vecs[4] = '{{16'h0000, 16'h0000, 16'hF800, 16'h0820}, -1, 1'b0, 1'b1, 16'd0, 16'd0, 17, 0};
        vecs[5] = '{{16'h0000, 16'hF800, 16'h0800, 16'hF000}, 0, 1'b1, 1'b0, 16'd2, 16'd3, 11, 2};

        // Reset state
        do_reset();
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_req", imem_req, 0);
        check("rst_we", rf_we, 0);
        check("rst_alu", alu_func, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);

        // Table-driven programs
        for (int v = 0; v < NV; v++) begin
            do_reset();
            load_prog(vecs[v].prog);
            resp_on    = (vecs[v].delay >= 0);
            resp_delay = (vecs[v].delay >= 0) ? vecs[v].delay : 0;
            run_until_done(200, cyc, pulses);
            check($sformatf("v%0d_halted", v), halted, vecs[v].exp_halted);
            check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("v%0d_cnt", v), instr_cnt, vecs[v].exp_cnt);
            check($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cycles);
            check($sformatf("v%0d_pulses", v), pulses, vecs[v].exp_pulses);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_req", v), imem_req, 0);
            check($sformatf("v%0d_q_empty", v), exp_q.size(), 0);
        end
        resp_on = 1'b1;

        // ALU op then HALT, zero wait, cycle by cycle
        do_reset();
        load_prog({16'h0000, 16'h0000, 16'hF800, 16'h0820});
        resp_delay = 0;
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("s1_req_c%0d", k), imem_req, (k == 1 || k == 5));
            check($sformatf("s1_we_c%0d", k), rf_we, (k == 4));
            check($sformatf("s1_alu_c%0d", k), alu_func, (k == 3 || k == 4) ? 1 : 0);
            check($sformatf("s1_halted_c%0d", k), halted, (k == 7));
        end
        check("s1_pc", pc, 2);
        check("s1_cnt", instr_cnt, 1);

        // Ack delayed by three cycles
        do_reset();
        load_prog({16'h0000, 16'h0000, 16'hF800, 16'h0820});
        resp_delay = 3;
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("s2_req_c%0d", k), imem_req, 1);
            check($sformatf("s2_addr_c%0d", k), imem_addr, 0);
            check($sformatf("s2_ir_c%0d", k), ir, 0);
        end
        @(negedge clk);
        check("s2_req_after", imem_req, 0);
        check("s2_ir_loaded", ir, 16'h0820);
        check("s2_pc", pc, 1);

        // Fetch timeout with no response
        do_reset();
        resp_on = 1'b0;
        req_cycles = 0;
        first_err = 0;
        start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (imem_req) req_cycles++;
            if (err && first_err == 0) first_err = k;
        end
        check("s3_req_cycles", req_cycles, 16);
        check("s3_first_err", first_err, 17);
        check("s3_err", err, 1);
        check("s3_pc", pc, 0);
        check("s3_req", imem_req, 0);
        check("s3_busy", busy, 0);
        resp_on = 1'b1;

        // NOP stream across the pc wrap, counter reaching saturation
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        resp_delay = 0;
        dut.pc_q  = 16'hFFFE;
        dut.cnt_q = 16'hFFFD;
        pc_m  = 16'hFFFE;
        cnt_m = 16'hFFFD;
        pulses = 0;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k % 2 == 0) pc_m = pc_m + 16'd1;
            if (k % 2 == 1 && k > 1) cnt_m = (cnt_m == 16'hFFFF) ? cnt_m : cnt_m + 16'd1;
            if (rf_we) pulses++;
            check($sformatf("s4_pc_c%0d", k), pc, pc_m);
            check($sformatf("s4_cnt_c%0d", k), instr_cnt, cnt_m);
        end
        check("s4_no_we", pulses, 0);

        // Reset while a fetch is answered in the same cycle
        do_reset();
        load_prog({16'h0000, 16'h0000, 16'hF800, 16'h0820});
        resp_on = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        manual = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = 16'h0820;
        rst = 1'b0;
        @(negedge clk);
        check("s5_state", 32'(fsm_state), 32'(ST_IDLE));
        check("s5_req", imem_req, 0);
        check("s5_busy", busy, 0);
        check("s5_pc", pc, 0);
        check("s5_ir", ir, 0);
        check("s5_alu", alu_func, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("s5_late_ack_ir", ir, 0);
        check("s5_late_ack_pc", pc, 0);
        check("s5_late_ack_state", 32'(fsm_state), 32'(ST_IDLE));
        imem_ack = 1'b0;
        manual   = 1'b0;
        resp_on  = 1'b1;
        exp_q.delete();
        run_until_done(200, cyc, pulses);
        check("s5_relaunch_halted", halted, 1);
        check("s5_relaunch_pc", pc, 2);
        check("s5_relaunch_cnt", instr_cnt, 1);
        check("s5_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpp16_sequencer.md
GPP16_SEQUENCER -- requirements
Module: gpp16_sequencer

Interface
REQ-001 SHALL have parameters: HALT_OPC, 5'b11111, opcode that stops execution.
REQ-002 SHALL have parameters: NOP_OPC, 5'b00000, opcode retired without register write.
REQ-003 SHALL have parameters: FETCH_TIMEOUT, 16, maximum FETCH cycles without imem_ack before error (range 2..255).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  begin execution from IDLE.
REQ-007 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  16  fetch address; imem_ack  in  1  fetch data valid; imem_data  in  16  fetched instruction.
REQ-008 SHALL have ports: pc  out  16  program counter; ir  out  16  instruction register.
REQ-009 SHALL have ports: alu_func  out  5  ALU function select; rf_we  out  1  register-file write enable.
REQ-010 SHALL have ports: busy  out  1  not IDLE/HALT/ERR; halted  out  1  in HALT; err  out  1  in ERR; instr_cnt  out  16  retired-instruction count.

Function
REQ-011 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR.
REQ-012 SHALL transition IDLE->FETCH on start=1; start in any other state is ignored.
REQ-013 SHALL in FETCH assert imem_req=1 with imem_addr=pc, held stable until imem_ack; there is no request withdrawal.
REQ-014 SHALL on imem_ack in FETCH load ir<=imem_data, set pc<=pc+1 (16-bit wrap, 16'hFFFF->0), and go to DECODE; the same-cycle ack with req is legal (zero wait).
REQ-015 SHALL ignore imem_ack in any state other than FETCH.
REQ-016 SHALL count FETCH cycles without ack; when the count reaches FETCH_TIMEOUT, go to ERR with pc and ir unchanged; the counter clears on entry to FETCH.
REQ-017 SHALL in DECODE go to HALT if ir[15:11]==HALT_OPC, else to FETCH with instr_cnt+1 if ir[15:11]==NOP_OPC, else to EXEC.
REQ-018 SHALL drive alu_func=ir[15:11] in EXEC and WB, and 5'b0 in all other states.
REQ-019 SHALL assert rf_we=1 only in WB, for exactly one cycle per non-NOP/non-HALT instruction.
REQ-020 SHALL in WB increment instr_cnt and go to FETCH.
REQ-021 SHALL saturate instr_cnt at 16'hFFFF.
REQ-022 SHALL make the ALU-instruction latency, with zero-wait ack, exactly 4 cycles FETCH->FETCH; a NOP takes 2 cycles and a HALT reaches HALT after 2 cycles.
REQ-023 SHALL keep HALT and ERR sticky until reset; imem_req=0 and rf_we=0 in both.
REQ-024 SHALL not increment instr_cnt for HALT.

Reset
REQ-025 SHALL on rst=0 at a clock edge set state=IDLE, pc=0, ir=0, instr_cnt=0, timeout counter=0.
REQ-026 SHALL force imem_req, rf_we, busy, halted and err to 0 and alu_func to 0 during reset.
REQ-027 SHALL, on reset mid-FETCH, drop imem_req in the cycle after the reset edge; a late ack is ignored.

Structure
REQ-028 SHALL place the state enum, opcode field positions, and HALT/NOP opcode constants in shared package gpp16_pkg.
REQ-029 SHALL implement the fetch timeout counter as sub-module gpp16_fetch_timer (clear, count enable, expired output).
REQ-030 SHALL drive all outputs from registered state/pc/ir; no combinational path from imem_data to any output.

Verification
REQ-031 SHALL cover: zero-wait ack; program 16'h0820 (opcode 1), 16'hF800 (HALT) -> rf_we one pulse at cycle 4 with alu_func=1, halted=1, instr_cnt=1, pc=2.
REQ-032 SHALL cover: ack delayed 3 cycles -> imem_req held for 4 cycles with imem_addr constant; ir loads only on the ack cycle.
REQ-033 SHALL cover: no ack, FETCH_TIMEOUT=16 -> err=1 after 16 FETCH cycles, pc=0, imem_req=0 thereafter.
REQ-034 SHALL cover: NOP stream from pc=16'hFFFE -> pc wraps to 0, instr_cnt increments every 2 cycles, rf_we never asserted.
REQ-035 SHALL cover: rst=0 during FETCH with ack pending -> next cycle IDLE, all outputs reset, subsequent ack ignored; start re-launches from pc=0.
